led_mode_scheduler: RTL

- Top-level scheduler for the LED mode drivers. It owns the single 8-bit LED bank and grants it to exactly one mode driver at a time.
- Mode changes come from a debounced user key or from an auto-cycle timer.
- Every switch inserts a blanking gap, holding the incoming driver in reset so it starts from a clean phase.
- Sits between the per-mode drivers (heartbeat, etc.) and the board LED pins.

---
 rtl/led_mode_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/led_mode_scheduler.sv
// LED bank scheduler: grants the 8-bit LED bank to one mode driver at a time,
// advancing on a debounced key press or auto timer, with a blanking gap.
module led_mode_scheduler #(
  parameter int NUM_MODES   = 4,
  parameter int DEB_CYC     = 240,
  parameter int BLANK_CYC   = 120,
  parameter int AUTO_PERIOD = 24000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn,
  input  logic                   auto_en,
  input  logic [NUM_MODES*8-1:0] mode_led,
  output logic [7:0]             led_out,
  output logic [2:0]             mode_sel,
  output logic [NUM_MODES-1:0]   drv_rst_n,
  output logic                   blanking,
  output logic                   mode_chg
);

  localparam int DW = $clog2(DEB_CYC) + 1;
  localparam int BW = $clog2(BLANK_CYC) + 1;
  localparam int AW = $clog2(AUTO_PERIOD) + 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYC - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);
  localparam logic [AW-1:0] AUTO_LAST  = AW'(AUTO_PERIOD - 1);
  localparam logic [2:0]    MODE_LAST  = 3'(NUM_MODES - 1);

  typedef enum logic {
    ST_RUN,
    ST_BLANK
  } state_e;

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 deb_q, deb_d;
  logic                 deb_dly_q;
  logic [DW-1:0]        dcnt_q, dcnt_d;
  logic [AW-1:0]        acnt_q, acnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  state_e               state_q, state_d;
  logic [2:0]           mode_q, mode_d;
  logic [7:0]           led_q, led_d;
  logic [NUM_MODES-1:0] drv_q, drv_d;
  logic                 blank_q, blank_d;
  logic                 chg_q, chg_d;

  logic                 btn_s;
  logic                 press;
  logic                 in_run;
  logic                 auto_evt;
  logic                 adv;
  logic [2:0]           mode_nxt;
  logic [7:0]           slice;
  logic [NUM_MODES-1:0] onehot;

  assign btn_s    = sync2_q;
  assign press    = deb_q & ~deb_dly_q;
  assign in_run   = (state_q == ST_RUN);
  assign auto_evt = in_run & auto_en & (acnt_q == AUTO_LAST);
  assign adv      = in_run & (press | auto_evt);
  assign mode_nxt = (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;

  // mode_q never exceeds MODE_LAST, so exactly one slot matches
  always_comb begin
    slice  = '0;
    onehot = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (mode_q == 3'(i)) begin
        slice     = mode_led[8*i +: 8];
        onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (btn_s != deb_q) begin
      if (dcnt_q == DEB_LAST) begin
        deb_d = btn_s;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  always_comb begin
    acnt_d = '0;
    if (in_run && auto_en && !adv) begin
      acnt_d = acnt_q + AW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    led_d   = '0;
    drv_d   = '0;
    blank_d = blank_q;
    chg_d   = 1'b0;
    bcnt_d  = '0;
    unique case (state_q)
      ST_RUN: begin
        if (adv) begin
          state_d = ST_BLANK;
          mode_d  = mode_nxt;
          blank_d = 1'b1;
          chg_d   = 1'b1;
        end else begin
          led_d   = slice;
          drv_d   = onehot;
          blank_d = 1'b0;
        end
      end
      ST_BLANK: begin
        if (bcnt_q == BLANK_LAST) begin
          state_d = ST_RUN;
          blank_d = 1'b0;
          drv_d   = onehot;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        blank_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      dcnt_q    <= '0;
      acnt_q    <= '0;
      bcnt_q    <= '0;
      state_q   <= ST_BLANK;
      mode_q    <= 3'd0;
      led_q     <= 8'd0;
      drv_q     <= '0;
      blank_q   <= 1'b1;
      chg_q     <= 1'b0;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      dcnt_q    <= dcnt_d;
      acnt_q    <= acnt_d;
      bcnt_q    <= bcnt_d;
      state_q   <= state_d;
      mode_q    <= mode_d;
      led_q     <= led_d;
      drv_q     <= drv_d;
      blank_q   <= blank_d;
      chg_q     <= chg_d;
    end
  end

  assign led_out   = led_q;
  assign mode_sel  = mode_q;
  assign drv_rst_n = drv_q;
  assign blanking  = blank_q;
  assign mode_chg  = chg_q;

endmodule
